aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Sequencer for AES-128 encryption. After reset it triggers round-key expansion in Key_Schedule,
//  then on each Start walks round keys 0..NR through Key_Schedule (En/SelKey/Ry) and issues
//  load/round strobes to the cipher round datapath. Sits between the host handshake and the
//  key schedule + round datapath.
// PARAMETERS
//  NR       10  number of cipher rounds; round keys 0..NR are used (NR <= 15, SelKey is 4 bits)
//  KEY_LAT  1   cycles from a SelKey change to Key valid at the key schedule output (>= 1)
// PORTS
//  Clk        in   1  clock, rising edge
//  Rst        in   1  reset, synchronous, active-high
//  Start      in   1  begin one block encryption; sampled only when Ready=1
//  Ready      out  1  idle and key expansion complete; Start is accepted
//  Busy       out  1  block in progress (S_SEL/S_APPLY/S_DONE)
//  Done       out  1  one-cycle pulse: final round applied, ciphertext valid next cycle
//  Ks_En      out  1  to Key_Schedule En
//  Ks_SelKey  out  4  to Key_Schedule SelKey (round-key index)
//  Ks_Ry      in   1  from Key_Schedule Ry (expansion complete)
//  Rnd_Load   out  1  datapath: state <= plaintext ^ Key (round 0 AddRoundKey)
//  Rnd_En     out  1  datapath: perform one round with current Key
//  Rnd_Last   out  1  qualifies Rnd_En: final round (no MixColumns)
//  Rnd_Num    out  4  current round index r
// BEHAVIOUR
//  - Moore FSM, outputs decoded from state/regs. States: S_KEXP, S_IDLE, S_SEL, S_APPLY, S_DONE.
//  - Rst (priority over all): state<=S_KEXP, r<=0, wait cnt<=0. Outputs in reset/after: Ks_En=1
//    (harmless, Key_Schedule also in reset), Ks_SelKey=0, Ready=Busy=Done=0, Rnd_*=0, Rnd_Num=0.
//  - S_KEXP: Ks_En = ~Ks_Ry. Ks_Ry=1 -> S_IDLE. No timeout; stays here while Ry=0.
//  - S_IDLE: Ready=1, Ks_SelKey held at 0. Start=1 -> r<=0, cnt<=0, S_SEL.
//  - S_SEL: Ks_SelKey=r; cnt counts 0..KEY_LAT-1; at cnt==KEY_LAT-1 -> S_APPLY.
//  - S_APPLY (one cycle): Ks_SelKey=r; r==0 -> Rnd_Load=1; r>0 -> Rnd_En=1; r==NR -> Rnd_Last=1
//    (with Rnd_En). r<NR -> r<=r+1, cnt<=0, S_SEL; r==NR -> S_DONE.
//  - S_DONE: Done=1 for one cycle -> S_IDLE. Back-to-back Start accepted the cycle Ready returns.
//  - Latency: Start sampled at edge t; Done high in cycle t+(NR+1)(KEY_LAT+1)+1 (23 at defaults).
//    Strobe count per block: exactly 1 Rnd_Load, NR Rnd_En, 1 Rnd_Last, 1 Done.
//  - Start while Ready=0 (incl. during S_KEXP): ignored, not queued.
//  - Ks_Ry dropping outside reset: no effect (only sampled in S_KEXP).
//  - Rst mid-block: block abandoned, no Done; key expansion re-runs, Ready after Ks_Ry.
//  - Rnd_Num = r in S_SEL/S_APPLY/S_DONE, 0 otherwise; r never exceeds NR (no wrap).
//  - Busy = ~Ready outside S_KEXP; Ready and Busy never both 1; both 0 in S_KEXP.
// STRUCTURE
//  - Shared header aes_defs.vh: AES_NR=10, AES_NK_BYTES=16, state encodings (3-bit), SELKEY_W=4.
//  - Single module; KEY_LAT wait counter width $clog2(KEY_LAT+1) inline. No sub-module.
//  - Top-level wiring: Ks_En/Ks_SelKey/Ks_Ry to Key_Schedule; Rst shared with Key_Schedule.
// TESTING
//  1 Reset release, Key_Schedule Ry after 1 cycle -> Ks_En=1 then 0, Ready=1 next cycle;
//    Start ignored before Ready.
//  2 Start in IDLE (defaults) -> Ks_SelKey 0,0,1,1..10,10; Rnd_Load in cycle 2; Rnd_En in cycles
//    4,6..22; Rnd_Last only at 22; Done in cycle 23.
//  3 FIPS-197 App. A key 2b7e1516.. with round datapath: Rnd_Load/Rnd_En each sample the round
//    key matching r (round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6).
//  4 Start held high continuously -> blocks run back-to-back, one Start accepted per Ready
//    cycle, Done every 24 cycles.
//  5 Rst asserted at r=5 in S_APPLY -> next cycle all strobes 0, Rnd_Num=0, no Done,
//    S_KEXP re-entered.
//  6 KEY_LAT=3, NR=10 -> each S_SEL lasts 3 cycles; Done 45 cycles after Start; strobe counts
//    1/10/1/1.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencer.
// Round count, key width, select width and FSM state encoding.
package aes_round_ctrl_pkg;

    localparam int AES_NR       = 10;
    localparam int AES_NK_BYTES = 16;
    localparam int SELKEY_W     = 4;

    typedef enum logic [2:0] {
        S_KEXP  = 3'd0,
        S_IDLE  = 3'd1,
        S_SEL   = 3'd2,
        S_APPLY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: runs key expansion after reset, then on
// each Start walks round keys 0..NR through the key schedule and strobes
// the round datapath.
//
// Ports:
//   Clk, Rst        clock / synchronous active-high reset
//   Start           begin one block (taken only while Ready)
//   Ready, Busy     idle-and-expanded / block in progress
//   Done            one-cycle pulse after the final round
//   Ks_En, Ks_SelKey, Ks_Ry   key schedule control and status
//   Rnd_Load, Rnd_En, Rnd_Last, Rnd_Num   round datapath control
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int KEY_LAT = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    output logic                Ready,
    output logic                Busy,
    output logic                Done,
    output logic                Ks_En,
    output logic [SELKEY_W-1:0] Ks_SelKey,
    input  logic                Ks_Ry,
    output logic                Rnd_Load,
    output logic                Rnd_En,
    output logic                Rnd_Last,
    output logic [SELKEY_W-1:0] Rnd_Num
);

    localparam int CNT_W = $clog2(KEY_LAT + 1);

    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(KEY_LAT - 1);
    localparam logic [SELKEY_W-1:0] LAST_R   = SELKEY_W'(NR);

    state_t              state, state_n;
    logic [SELKEY_W-1:0] r, r_n;
    logic [CNT_W-1:0]    cnt, cnt_n;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_KEXP;
            r     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        cnt_n   = cnt;
        unique case (state)
            S_KEXP: begin
                if (Ks_Ry)
                    state_n = S_IDLE;
            end
            S_IDLE: begin
                if (Start) begin
                    r_n     = '0;
                    cnt_n   = '0;
                    state_n = S_SEL;
                end
            end
            S_SEL: begin
                // Hold SelKey until the key schedule output settles.
                if (cnt == LAST_CNT)
                    state_n = S_APPLY;
                else
                    cnt_n = cnt + 1'b1;
            end
            S_APPLY: begin
                if (r == LAST_R) begin
                    state_n = S_DONE;
                end else begin
                    r_n     = r + 1'b1;
                    cnt_n   = '0;
                    state_n = S_SEL;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_KEXP;
            end
        endcase
    end

    always_comb begin
        Ready     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Ks_En     = 1'b0;
        Ks_SelKey = '0;
        Rnd_Load  = 1'b0;
        Rnd_En    = 1'b0;
        Rnd_Last  = 1'b0;
        Rnd_Num   = '0;
        unique case (state)
            S_KEXP: begin
                Ks_En = ~Ks_Ry;
            end
            S_IDLE: begin
                Ready = 1'b1;
            end
            S_SEL: begin
                Busy      = 1'b1;
                Ks_SelKey = r;
                Rnd_Num   = r;
            end
            S_APPLY: begin
                Busy      = 1'b1;
                Ks_SelKey = r;
                Rnd_Num   = r;
                // Round 0 is the initial AddRoundKey only.
                Rnd_Load  = (r == '0);
                Rnd_En    = (r != '0);
                Rnd_Last  = (r == LAST_R);
            end
            S_DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                Ks_SelKey = r;
                Rnd_Num   = r;
            end
            default: begin
                Ks_En = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl (default and KEY_LAT=3 instances).
// Key schedule is modelled as a FIPS-197 round-key table with latency.
module tb_aes_round_ctrl;

    logic       Clk = 1'b0;
    logic       Rst, Start, Start3, Ks_Ry;

    logic       ready, busy, done, ks_en;
    logic [3:0] ks_sel, rnd_num;
    logic       rnd_load, rnd_en, rnd_last;

    logic       ready3, busy3, done3, ks_en3;
    logic [3:0] ks_sel3, rnd_num3;
    logic       rnd_load3, rnd_en3, rnd_last3;

    logic [127:0] rk [0:10];
    logic [127:0] kp;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    aes_round_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Start(Start),
        .Ready(ready), .Busy(busy), .Done(done),
        .Ks_En(ks_en), .Ks_SelKey(ks_sel), .Ks_Ry(Ks_Ry),
        .Rnd_Load(rnd_load), .Rnd_En(rnd_en),
        .Rnd_Last(rnd_last), .Rnd_Num(rnd_num)
    );

    aes_round_ctrl #(.NR(10), .KEY_LAT(3)) dut3 (
        .Clk(Clk), .Rst(Rst), .Start(Start3),
        .Ready(ready3), .Busy(busy3), .Done(done3),
        .Ks_En(ks_en3), .Ks_SelKey(ks_sel3), .Ks_Ry(Ks_Ry),
        .Rnd_Load(rnd_load3), .Rnd_En(rnd_en3),
        .Rnd_Last(rnd_last3), .Rnd_Num(rnd_num3)
    );

    // One-cycle key schedule: Key follows SelKey one edge later.
    always_ff @(posedge Clk)
        kp <= (ks_sel <= 4'd10) ? rk[ks_sel] : '0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int idx;
    bit ap;
    int n_ld, n_en, n_last, n_done;

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset and key expansion; Start ignored before Ready.
        Rst = 1'b1; Start = 1'b0; Start3 = 1'b0; Ks_Ry = 1'b0;
        tick(); tick();
        chk("rst_ks_en", ks_en, 1'b1);
        chk("rst_state",
            {ready, busy, done, ks_sel, rnd_load, rnd_en, rnd_last, rnd_num},
            14'd0);
        Rst = 1'b0; Start = 1'b1;
        tick();
        chk("kexp_ks_en", ks_en, 1'b1);
        chk("kexp_rdy_bsy", {ready, busy}, 2'b00);
        Ks_Ry = 1'b1; Start = 1'b0;
        #1;
        chk("kexp_ry_ks_en", ks_en, 1'b0);
        chk("kexp_ry_ready", ready, 1'b0);
        tick();
        chk("idle_ready", {ready, busy}, 2'b10);
        chk("idle_sel", ks_sel, 4'd0);
        tick();
        chk("start_not_queued", {ready, busy}, 2'b10);
        Ks_Ry = 1'b0;
        tick();
        chk("ry_drop_ignored", {ready, busy, ks_en}, 3'b100);
        Ks_Ry = 1'b1;

        // One block at defaults, with key-schedule alignment.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            idx = (c - 1) / 2;
            ap  = (c % 2 == 0);
            if (c <= 22) begin
                chk($sformatf("blk_c%0d", c),
                    {ready, busy, done, ks_sel,
                     rnd_load, rnd_en, rnd_last, rnd_num},
                    {1'b0, 1'b1, 1'b0, 4'(idx),
                     ap && idx == 0, ap && idx > 0,
                     ap && idx == 10, 4'(idx)});
                if (ap)
                    chk($sformatf("blk_key_r%0d", idx), kp, rk[idx]);
            end else begin
                chk("blk_done",
                    {ready, busy, done, rnd_load, rnd_en, rnd_last, rnd_num},
                    {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10});
            end
            if (c == 22)
                chk("blk_key_r10_fips", kp,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            tick();
        end
        chk("blk_back_idle",
            {ready, busy, done, ks_sel, rnd_num}, {3'b100, 4'd0, 4'd0});

        // Start held high: back-to-back blocks, Done every 24 cycles.
        Start = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            tick();
            chk($sformatf("b2b_done_k%0d", k), done, 1'(k % 24 == 23));
            chk($sformatf("b2b_ready_k%0d", k), ready, 1'(k % 24 == 0));
        end
        Start = 1'b0;
        tick();
        chk("b2b_stop_idle", {ready, busy}, 2'b10);

        // Reset during round 5 apply.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 2; c <= 12; c++)
            tick();
        chk("mid_r5_apply", {rnd_en, rnd_num}, {1'b1, 4'd5});
        Rst = 1'b1; Ks_Ry = 1'b0;
        tick();
        chk("mid_rst_out",
            {ready, busy, done, ks_sel, rnd_load, rnd_en, rnd_last, rnd_num},
            14'd0);
        chk("mid_rst_ks_en", ks_en, 1'b1);
        Rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_kexp_%0d", c),
                {ready, busy, done, ks_en}, 4'b0001);
        end
        Ks_Ry = 1'b1;
        tick();
        chk("mid_ready_again", {ready, busy, done}, 3'b100);

        // KEY_LAT=3 instance.
        n_ld = 0; n_en = 0; n_last = 0; n_done = 0;
        Start3 = 1'b1;
        tick();
        Start3 = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            idx = (c - 1) / 4;
            ap  = (c % 4 == 0);
            if (c <= 44)
                chk($sformatf("lat3_c%0d", c),
                    {ready3, busy3, done3, ks_sel3,
                     rnd_load3, rnd_en3, rnd_last3, rnd_num3},
                    {1'b0, 1'b1, 1'b0, 4'(idx),
                     ap && idx == 0, ap && idx > 0,
                     ap && idx == 10, 4'(idx)});
            else
                chk("lat3_done", {done3, busy3, rnd_num3}, {2'b11, 4'd10});
            n_ld   += int'(rnd_load3);
            n_en   += int'(rnd_en3);
            n_last += int'(rnd_last3);
            n_done += int'(done3);
            tick();
        end
        chk("lat3_idle", {ready3, busy3, done3}, 3'b100);
        chk("lat3_counts", {n_ld[7:0], n_en[7:0], n_last[7:0], n_done[7:0]},
            {8'd1, 8'd10, 8'd1, 8'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
